// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers and defaults
//
// Contents:
//   GRAY_DEFAULT_WIDTH : default counter width
//   to_gray(bin)       : binary to reflected Gray code, bin ^ (bin >> 1)
package gray_pkg;

    localparam int GRAY_DEFAULT_WIDTH = 4;

    // Operates on a 32-bit container so callers of any width up to 32 can
    // zero-extend into it; the high bits of the result stay zero.
    function automatic logic [31:0] to_gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/binary_to_gray.sv
// rtl/binary_to_gray.sv - combinational binary to Gray-code converter
//
// Ports:
//   bin  : input  [WIDTH-1:0] binary value
//   gray : output [WIDTH-1:0] reflected Gray code of bin
module binary_to_gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Each Gray bit is the XOR of a binary bit and its upper neighbour; the
    // MSB passes straight through.
    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - registered up/down Gray-code counter with load and wrap
//
// Ports:
//   clk      : input             rising-edge clock
//   rst_n    : input             asynchronous active-low reset
//   en       : input             count enable, one step per clock
//   up_dn    : input             1 = increment, 0 = decrement
//   load     : input             synchronous load of load_val, overrides en
//   load_val : input [WIDTH-1:0] binary value to load
//   bin_out  : output[WIDTH-1:0] registered binary count
//   gray_out : output[WIDTH-1:0] registered Gray code of bin_out
//   wrap     : output            one-cycle pulse when the count wraps
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    // Next-state mux: load beats en beats hold. Wrap is decided from the
    // current count so it lands in the same cycle as the wrapped value.
    always_comb begin
        bin_next  = bin_out;
        wrap_next = 1'b0;
        if (load) begin
            bin_next = load_val;
        end else if (en) begin
            if (up_dn) begin
                bin_next  = bin_out + ONE;
                wrap_next = &bin_out;
            end else begin
                bin_next  = bin_out - ONE;
                wrap_next = ~|bin_out;
            end
        end
    end

    // Gray is taken from the same next-binary value and registered alongside
    // it, so gray_out is a pure flop output and always matches bin_out.
    binary_to_gray #(
        .WIDTH (WIDTH)
    ) u_binary_to_gray (
        .bin  (bin_next),
        .gray (gray_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out  <= '0;
            gray_out <= '0;
            wrap     <= 1'b0;
        end else begin
            bin_out  <= bin_next;
            gray_out <= gray_next;
            wrap     <= wrap_next;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - randomized self-checking bench for gray_counter
module tb_gray_counter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] bin_out;
    logic [W-1:0] gray_out;
    logic         wrap;

    int total = 0;
    int bad   = 0;

    // Reference state: plain integer count and expected wrap flag.
    int m_bin  = 0;
    int m_wrap = 0;

    always #5 clk = ~clk;

    gray_counter #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .bin_out  (bin_out),
        .gray_out (gray_out),
        .wrap     (wrap)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    // Downstream gray_to_binary: each binary bit is the XOR of all Gray bits
    // at or above it.
    function automatic int gray_decode(input int g);
        int b;
        int acc;
        b   = 0;
        acc = 0;
        for (int i = W - 1; i >= 0; i--) begin
            acc = acc ^ ((g >> i) & 1);
            b   = b | (acc << i);
        end
        return b;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_bin"},  int'(bin_out),  m_bin);
        check({tag, "_gray"}, int'(gray_out), gray_of(m_bin));
        check({tag, "_wrap"}, int'(wrap),     m_wrap);
        check({tag, "_rt"},   gray_decode(int'(gray_out)), m_bin);
    endtask

    task automatic tick(input string tag);
        int old_gray;
        int was_step;
        old_gray = int'(gray_out);
        was_step = (!load && en) ? 1 : 0;
        @(posedge clk);
        #1;
        if (load) begin
            m_bin  = int'(load_val);
            m_wrap = 0;
        end else if (en) begin
            if (up_dn) begin
                m_wrap = (m_bin == MAXV) ? 1 : 0;
                m_bin  = (m_bin + 1) % (MAXV + 1);
            end else begin
                m_wrap = (m_bin == 0) ? 1 : 0;
                m_bin  = (m_bin + MAXV) % (MAXV + 1);
            end
        end else begin
            m_wrap = 0;
        end
        check_outputs(tag);
        if (was_step != 0)
            check({tag, "_onebit"}, $countones(int'(gray_out) ^ old_gray), 1);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        m_bin  = 0;
        m_wrap = 0;
        check_outputs("reset");
        rst_n = 1'b1;
    endtask

    task automatic set_in(input logic l, input logic [W-1:0] lv,
                          input logic e, input logic u);
        load     = l;
        load_val = lv;
        en       = e;
        up_dn    = u;
    endtask

    initial begin
        // Reset then 17 up steps through a full wrap.
        do_reset();
        set_in(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) begin
            tick("up");
            if (i == 15) check("up_wrap16", int'(wrap), 1);
        end

        // Down through zero from reset.
        do_reset();
        set_in(1'b0, '0, 1'b1, 1'b0);
        tick("down0");
        check("down0_gray_const", int'(gray_out), 8);
        set_in(1'b0, '0, 1'b0, 1'b0);
        tick("down0_hold");

        // Load beats en.
        set_in(1'b1, 4'b1010, 1'b1, 1'b1);
        tick("loadpri");
        check("loadpri_gray_const", int'(gray_out), 15);
        set_in(1'b0, '0, 1'b1, 1'b1);
        tick("loadpri_up");
        check("loadpri_up_gray_const", int'(gray_out), 14);

        // Load of max value never wraps; the following step does.
        set_in(1'b1, 4'b1111, 1'b0, 1'b1);
        tick("loadmax");
        set_in(1'b0, '0, 1'b1, 1'b1);
        tick("loadmax_up");
        check("loadmax_up_wrap_const", int'(wrap), 1);

        // Hold then direction change.
        set_in(1'b1, 4'b0100, 1'b0, 1'b1);
        tick("to4");
        set_in(1'b0, '0, 1'b1, 1'b1);
        tick("to5");
        set_in(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick("hold");
        set_in(1'b0, '0, 1'b1, 1'b0);
        tick("dirchg");
        check("dirchg_gray_const", int'(gray_out), 6);

        // Async reset mid-cycle at count 6.
        set_in(1'b1, 4'b0110, 1'b0, 1'b1);
        tick("to6");
        set_in(1'b0, '0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        m_bin  = 0;
        m_wrap = 0;
        check_outputs("arst");
        #1;
        rst_n = 1'b1;
        tick("arst_resume");

        // Async reset clears a wrap pulse in flight.
        set_in(1'b1, 4'b1111, 1'b0, 1'b1);
        tick("to15");
        set_in(1'b0, '0, 1'b1, 1'b1);
        tick("wrapflight");
        #2;
        rst_n = 1'b0;
        #1;
        m_bin  = 0;
        m_wrap = 0;
        check_outputs("arst_wrap");
        #1;
        rst_n = 1'b1;
        tick("arst_wrap_resume");

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            set_in(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                   W'($urandom_range(0, MAXV)),
                   ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                   1'($urandom_range(0, 1)));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Registered Gray-code counter that produces the Gray-coded sequence consumed by the downstream gray_to_binary stage.
- Used as the pointer generator for future clock-domain-crossing FIFOs, so the output must be registered and glitch-free, with exactly one bit changing per count step.
- Keeps an internal binary count. Gray output is derived from the next binary value and registered in the same cycle, so both outputs always agree.

Parameters:
- WIDTH, 4, counter width in bits (must be >= 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  count enable; one step per clock while high
- up_dn  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous load of load_val; overrides en
- load_val  input  WIDTH  binary value to load
- bin_out  output  WIDTH  registered binary count
- gray_out  output  WIDTH  registered Gray code of bin_out: bin_out ^ (bin_out >> 1)
- wrap  output  1  one-cycle pulse when the count wraps

Behaviour:
- Reset: rst_n low asynchronously forces bin_out = 0, gray_out = 0, wrap = 0. Release is synchronous to the next clk edge in the design flow. The first count step occurs on the first rising edge after rst_n is high.
- Priority each rising edge: load > en > hold.
- load = 1:
  - bin_out <= load_val; gray_out <= gray(load_val); wrap <= 0.
  - en and up_dn are ignored.
  - A loaded value may change multiple Gray bits; this is the only case where that is allowed.
- load = 0, en = 1, up_dn = 1: bin_out <= bin_out + 1, modulo 2^WIDTH.
- load = 0, en = 1, up_dn = 0: bin_out <= bin_out - 1, modulo 2^WIDTH.
- load = 0, en = 0: all registers hold; wrap <= 0.
- gray_out is always registered from the same next-binary value as bin_out. No combinational path from any input to gray_out.
- Latency: one clock from an en or load edge to the updated outputs.
- wrap is registered and asserts for exactly one cycle, coincident with the new count:
  - up step from 2^WIDTH-1 to 0
  - down step from 0 to 2^WIDTH-1
- wrap is never asserted by load, even when load_val is 0 or the max value.
- Direction change mid-sequence takes effect on the next step with no extra latency. Example: 5 up gives 6; then down gives 5.
- Continuous en across a wrap: the count continues with no stall cycle.
- Invariant: on every en step (not load), popcount(gray_out_new ^ gray_out_old) == 1.
- Reset asserted mid-count: outputs go to 0 immediately, independent of clk. A wrap pulse in flight is cleared.

Decomposition:
- Shared package gray_pkg:
  - function to_gray(bin), returning bin ^ (bin >> 1)
  - constant GRAY_DEFAULT_WIDTH = 4
- Sub-module: reuse the existing combinational binary_to_gray, instantiated on the next-binary value before the output register. No new sub-module is needed.
- The counter core (next-state mux, wrap detect, registers) stays in gray_counter.

Test Plan:
- Reset then count up: rst_n = 0 for 2 cycles, release, en = 1, up_dn = 1 for 17 cycles.
  - gray_out sequence: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, ..., 1000, 0000.
  - wrap = 1 only in the cycle bin_out returns to 0000.
  - Exactly one gray bit changes per step.
- Count down through zero: from reset, en = 1, up_dn = 0 for 1 cycle.
  - bin_out = 1111, gray_out = 1000, wrap = 1; next cycle with en = 0 gives wrap = 0.
- Load priority: load = 1, load_val = 1010, en = 1 in the same cycle.
  - bin_out = 1010, gray_out = 1111, wrap = 0.
  - Next en up step gives bin_out = 1011, gray_out = 1110.
- Load at max with no wrap: load_val = 1111 gives wrap = 0.
  - Next up step gives bin_out = 0000, gray_out = 0000, wrap = 1.
- Hold and direction change: count to 0101 (gray 0111), drop en for 3 cycles (outputs stable, wrap = 0), then en = 1, up_dn = 0.
  - bin_out = 0100, gray_out = 0110.
- Async reset mid-count: at bin_out = 0110, pulse rst_n low between clk edges.
  - bin_out = 0000, gray_out = 0000, wrap = 0 before the next edge.
  - Counting resumes from 0001 after release.
- Round trip in all scenarios: feed gray_out into gray_to_binary; its output must equal bin_out every cycle.
